// File: rtl/ao_div_pkg.sv
// rtl/ao_div_pkg.sv - shared types and constants for the radix-4 divider
package ao_div_pkg;

    localparam int WIDTH      = 16;
    localparam int ITER_STEPS = WIDTH / 2;

    localparam logic [15:0] QUOT_DIV0 = 16'hFFFF;
    localparam logic [15:0] QUOT_OVF  = 16'h8000;
    localparam logic [15:0] MIN_NEG   = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_t;

    // Magnitude of a two's complement value; -32768 maps to 0x8000.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/ao_rad4_digit_sel.sv
// rtl/ao_rad4_digit_sel.sv - radix-4 restoring digit selection and remainder update
module ao_rad4_digit_sel (
    input  logic [17:0] rem_shift,
    input  logic [17:0] d1,
    input  logic [17:0] d2,
    input  logic [17:0] d3,
    output logic [1:0]  digit,
    output logic [15:0] rem_next
);

    // Pick the largest multiple of D that fits; the remainder after
    // subtraction is always below D, so 16 bits are enough.
    always_comb begin
        digit    = 2'd0;
        rem_next = rem_shift[15:0];
        if (rem_shift >= d3) begin
            digit    = 2'd3;
            rem_next = rem_shift[15:0] - d3[15:0];
        end else if (rem_shift >= d2) begin
            digit    = 2'd2;
            rem_next = rem_shift[15:0] - d2[15:0];
        end else if (rem_shift >= d1) begin
            digit    = 2'd1;
            rem_next = rem_shift[15:0] - d1[15:0];
        end
    end

endmodule

// File: rtl/ao_rad4_div16.sv
// rtl/ao_rad4_div16.sv - 16-bit signed radix-4 divider, optional APPROX_DIV_EN truncation
module ao_rad4_div16 #(
    parameter int WIDTH       = 16,
    parameter int TRUNC_STEPS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero,
    output logic             overflow
);

    import ao_div_pkg::*;

    if (WIDTH != 16 || TRUNC_STEPS < 0 || TRUNC_STEPS > 7) begin : g_cfg_check
        $error("ao_rad4_div16: WIDTH must be 16 and TRUNC_STEPS 0..7");
    end

`ifdef APPROX_DIV_EN
    localparam int TRUNC_EFF = TRUNC_STEPS;
`else
    localparam int TRUNC_EFF = 0;
`endif
    localparam int          ITER_RUN = ITER_STEPS - TRUNC_EFF;
    localparam logic [2:0]  CNT_LAST = 3'(ITER_RUN - 1);

    div_state_t  state_q, state_d;
    logic [15:0] a_shift_q, a_shift_d;
    logic [15:0] b_abs_q, b_abs_d;
    logic        qsign_q, qsign_d;
    logic        rsign_q, rsign_d;
    logic        bneg_q, bneg_d;
    logic [17:0] d1_q, d1_d;
    logic [17:0] d2_q, d2_d;
    logic [17:0] d3_q, d3_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] q_q, q_d;
    logic [15:0] r_q, r_d;
    logic        dbz_q, dbz_d;
    logic        ovf_q, ovf_d;

    logic [17:0] rem_shift;
    logic [1:0]  digit;
    logic [15:0] rem_next;
    logic [15:0] quo_mag;

    assign rem_shift = {rem_q, a_shift_q[15:14]};
    assign quo_mag   = quo_q << (2 * TRUNC_EFF);

    ao_rad4_digit_sel u_digit_sel (
        .rem_shift (rem_shift),
        .d1        (d1_q),
        .d2        (d2_q),
        .d3        (d3_q),
        .digit     (digit),
        .rem_next  (rem_next)
    );

    assign in_ready    = (state_q == IDLE) && !rst;
    assign out_valid   = (state_q == DONE);
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

    // Next-state and datapath: capture, special cases, iterate, sign fix, hold.
    always_comb begin
        state_d   = state_q;
        a_shift_d = a_shift_q;
        b_abs_d   = b_abs_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        bneg_d    = bneg_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        d3_d      = d3_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        r_d       = r_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_shift_d = abs16(a);
                    b_abs_d   = abs16(b);
                    qsign_d   = a[15] ^ b[15];
                    rsign_d   = a[15];
                    bneg_d    = b[15];
                    state_d   = PREP;
                end
            end
            PREP: begin
                if (b_abs_q == 16'd0) begin
                    q_d     = QUOT_DIV0;
                    r_d     = rsign_q ? (~a_shift_q + 16'd1) : a_shift_q;
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end else if (a_shift_q == MIN_NEG && b_abs_q == 16'd1 && bneg_q) begin
                    q_d     = QUOT_OVF;
                    r_d     = 16'd0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    d1_d    = {2'b00, b_abs_q};
                    d2_d    = {1'b0, b_abs_q, 1'b0};
                    d3_d    = {2'b00, b_abs_q} + {1'b0, b_abs_q, 1'b0};
                    rem_d   = 16'd0;
                    quo_d   = 16'd0;
                    cnt_d   = 3'd0;
                    state_d = ITER;
                end
            end
            ITER: begin
                rem_d     = rem_next;
                quo_d     = {quo_q[13:0], digit};
                a_shift_d = {a_shift_q[13:0], 2'b00};
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                q_d = qsign_q ? (~quo_mag + 16'd1) : quo_mag;
`ifdef APPROX_DIV_EN
                r_d = 16'd0;
`else
                r_d = rsign_q ? (~rem_q + 16'd1) : rem_q;
`endif
                dbz_d   = 1'b0;
                ovf_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_shift_q <= 16'd0;
            b_abs_q   <= 16'd0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            bneg_q    <= 1'b0;
            d1_q      <= 18'd0;
            d2_q      <= 18'd0;
            d3_q      <= 18'd0;
            rem_q     <= 16'd0;
            quo_q     <= 16'd0;
            cnt_q     <= 3'd0;
            q_q       <= 16'd0;
            r_q       <= 16'd0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_shift_q <= a_shift_d;
            b_abs_q   <= b_abs_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            bneg_q    <= bneg_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            d3_q      <= d3_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            r_q       <= r_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ao_rad4_div16.sv
// tb/tb_ao_rad4_div16.sv - scoreboard bench for ao_rad4_div16 (APPROX_DIV_EN aware)
module tb_ao_rad4_div16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] q;
    logic [15:0] r;
    logic        div_by_zero;
    logic        overflow;

`ifdef APPROX_DIV_EN
    localparam int LAT_N = 9;
`else
    localparam int LAT_N = 11;
`endif
    localparam int LAT_S = 2;

    ao_rad4_div16 #(.WIDTH(16), .TRUNC_STEPS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    logic prev_valid = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid) begin
                chk("in_ready_while_valid", {31'd0, in_ready}, 32'd0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got q=0x%0h r=0x%0h, expected no result", q, r);
                end else begin
                    e = sb[0];
                    if (!prev_valid) chk("latency_edges", 32'(cyc - e.acc + 1), 32'(e.lat));
                    chk("q", {16'd0, q}, {16'd0, e.q});
                    chk("r", {16'd0, r}, {16'd0, e.r});
                    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                    chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_valid <= out_valid;
        end
    end

    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic push,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edbz, input logic eovf, input int elat, output int acc);
        int   guard;
        exp_t x;
        guard    = 0;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            acc      = -1;
            return;
        end
        acc   = cyc + 1;
        x.q   = eq;
        x.r   = er;
        x.dbz = edbz;
        x.ovf = eovf;
        x.lat = elat;
        x.acc = acc;
        if (push) sb.push_back(x);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edbz, input logic eovf, input int elat);
        int acc;
        issue(av, bv, 1'b1, eq, er, edbz, eovf, elat, acc);
        drain();
    endtask

    initial begin
        int acc;
        logic [15:0] av, bv;
        int sa, sd;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_q", {16'd0, q}, 32'd0);
        chk("rst_r", {16'd0, r}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2;

        // Special cases are identical in both builds.
        run(16'd5,     16'd0,     16'hFFFF, 16'd5,     1'b1, 1'b0, LAT_S);
        run(16'hFFFB,  16'd0,     16'hFFFF, 16'hFFFB,  1'b1, 1'b0, LAT_S);
        run(16'h8000,  16'hFFFF,  16'h8000, 16'd0,     1'b0, 1'b1, LAT_S);
        run(16'h8000,  16'd1,     16'h8000, 16'd0,     1'b0, 1'b0, LAT_N);
        run(16'd0,     16'd5,     16'd0,    16'd0,     1'b0, 1'b0, LAT_N);

`ifndef APPROX_DIV_EN
        run(16'd100,   16'd7,     16'd14,   16'd2,     1'b0, 1'b0, LAT_N);
        run(16'hFF9C,  16'd7,     16'hFFF2, 16'hFFFE,  1'b0, 1'b0, LAT_N);
        run(16'd100,   16'hFFF9,  16'hFFF2, 16'd2,     1'b0, 1'b0, LAT_N);
        run(16'h7FFF,  16'h8000,  16'd0,    16'h7FFF,  1'b0, 1'b0, LAT_N);
`endif

        // Backpressure: result must be held while out_ready is low.
        out_ready = 1'b0;
`ifdef APPROX_DIV_EN
        issue(16'd1000, 16'd3, 1'b1, 16'd320, 16'd0, 1'b0, 1'b0, LAT_N, acc);
`else
        issue(16'd1000, 16'd3, 1'b1, 16'd333, 16'd1, 1'b0, 1'b0, LAT_N, acc);
`endif
        repeat (32) @(negedge clk);
        chk("bp_result_held", 32'(sb.size()), 32'd1);
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_out_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2;

        // Reset on the 4th ITER cycle aborts the operation silently.
        issue(16'd1234, 16'd5, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 0, acc);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("after_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #2;
`ifdef APPROX_DIV_EN
        run(16'hFFF7, 16'd2, 16'd0, 16'd0, 1'b0, 1'b0, LAT_N);
`else
        run(16'hFFF7, 16'd2, 16'hFFFC, 16'hFFFF, 1'b0, 1'b0, LAT_N);

        // Random sweep against truncating signed integer division.
        for (int i = 0; i < 12; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            if (i % 3 == 0) bv = 16'($urandom_range(1, 40));
            if (bv == 16'd0) bv = 16'd3;
            if (av == 16'h8000 && bv == 16'hFFFF) bv = 16'd1;
            sa = int'($signed(av));
            sd = int'($signed(bv));
            run(av, bv, 16'(sa / sd), 16'(sa % sd), 1'b0, 1'b0, LAT_N);
        end
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ao_rad4_div16.md
Name: ao_rad4_div16

Overview:
- Sequential 16-bit signed radix-4 restoring divider. It is the inverse companion to the approximate radix-4 Booth multipliers and lives in the same non-logarithmic arithmetic library.
- Takes dividend/divisor over a valid/ready handshake and resolves 2 quotient bits per clock.
- Returns a truncating (round-toward-zero) quotient and remainder over a second valid/ready handshake.
- An optional approximate mode skips the low-order iterations, mirroring the library's approximate multipliers.

Parameters:
- WIDTH, 16, operand/result width; fixed at 16, must be even.
- TRUNC_STEPS, 2, radix-4 iterations skipped when APPROX_DIV_EN is defined (0..7); ignored otherwise.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block idle, can accept
- a  in  16  dividend, signed two's complement
- b  in  16  divisor, signed two's complement
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- q  out  16  quotient, signed
- r  out  16  remainder, signed, sign follows a
- div_by_zero  out  1  b was 0 for this result
- overflow  out  1  a=-32768, b=-1 for this result

Behaviour:
- One clock domain; synchronous, active-high reset (fixed). While rst=1: state=IDLE, in_ready=0, out_valid=0, q=r=0, div_by_zero=overflow=0. From the first cycle after rst=0: in_ready=1.
- in_ready = (state==IDLE) && !rst. Operands are captured on an edge where in_valid && in_ready.
- State IDLE: on accept, register |a| and |b| as 16-bit unsigned (|-32768| = 0x8000), plus sign_q = a[15]^b[15] and sign_r = a[15] -> PREP.
- State PREP (1 cycle):
  - b==0: q=0xFFFF, r=a, div_by_zero=1 -> DONE.
  - a==0x8000 && b==0xFFFF: q=0x8000, r=0, overflow=1 -> DONE.
  - Otherwise: compute D, 2D, 3D as 18-bit values, clear the partial remainder R (16 bits) and step counter -> ITER.
- State ITER (8 cycles): each cycle:
  - R' = {R, next two MSBs of |a|} (18 bits).
  - Digit d = largest k in {3,2,1,0} with k*D <= R'.
  - R = R' - d*D; shift d into the quotient LSBs.
  - After the 8th step -> FIX.
- State FIX (1 cycle): q = sign_q ? -Q : Q; r = sign_r ? -R : R; flags = 0 -> DONE.
- State DONE: out_valid=1; q/r/flags held stable until out_ready. On out_valid && out_ready -> IDLE, and out_valid drops next cycle.
- Latency:
  - Normal path: out_valid rises 11 edges after the accept edge (PREP 1 + ITER 8 + FIX 1 + DONE entry).
  - Zero-divisor/overflow path: 2 edges.
  - Minimum initiation interval: 12 cycles (DONE->IDLE costs one cycle; in_ready is never high in the same cycle as out_valid).
- Backpressure: out_ready low holds DONE indefinitely with stable outputs; in_valid is ignored while busy.
- in_valid with a or b changing while not accepted has no effect.
- rst asserted in any state (including mid-ITER) aborts the operation; no result is emitted for it.
- Invariant for exact results: a == q*b + r, |r| < |b|, r==0 or sign(r)==sign(a).

Optional Feature:
- APPROX_DIV_EN defined:
  - ITER runs 8-TRUNC_STEPS cycles using the top 2*(8-TRUNC_STEPS) dividend bits.
  - Quotient magnitude low 2*TRUNC_STEPS bits are forced 0; r is forced to 0x0000.
  - Normal-path latency is reduced by TRUNC_STEPS.
  - Special cases (zero divisor, overflow) are unchanged.
- APPROX_DIV_EN undefined: exact 8-iteration behaviour; TRUNC_STEPS is unused.

Decomposition:
- Package ao_div_pkg holds:
  - state enum (IDLE, PREP, ITER, FIX, DONE)
  - WIDTH, ITER_STEPS = WIDTH/2
  - special-case constants: QUOT_DIV0 = 0xFFFF, QUOT_OVF = 0x8000, MIN_NEG = 0x8000
- One natural sub-module: ao_rad4_digit_sel. It is combinational: takes R' (18b), D, 2D, 3D and returns digit (2b) plus the next remainder (16b).

Test Plan:
- a=100, b=7 -> after 11 edges: q=14, r=2, flags=0. Same with a=-100 -> q=0xFFF2, r=0xFFFE. With b=-7, a=100 -> q=0xFFF2, r=2.
- a=5, b=0 -> out_valid after 2 edges: q=0xFFFF, r=5, div_by_zero=1, overflow=0.
- a=0x8000, b=0xFFFF -> q=0x8000, r=0, overflow=1 after 2 edges. Also a=0x8000, b=1 -> q=0x8000, r=0, normal 11-edge path.
- Backpressure: a=1000, b=3 with out_ready=0 for 20 cycles -> q=333, r=1 held stable, in_ready=0 throughout. out_ready=1 -> out_valid falls next cycle, in_ready rises.
- Reset mid-ITER (rst on 4th ITER cycle) -> out_valid=0, in_ready=1 after release. A new a=-9, b=2 then gives q=0xFFFC, r=0xFFFF.
- APPROX_DIV_EN, TRUNC_STEPS=2: a=1000, b=3 -> q=320 (0x0140), r=0, out_valid after 9 edges. Random exact-mode sweep checks the invariant.
